// File: rtl/multi_tick_gen.sv
// Multi-channel run-time programmable tick generator: NUM_CH independent divide-by-div[i] pulses.
// Optional macro TICK_GEN_SQUARE_EN adds a per-channel square-wave output sq.

module tick_lane #(
  parameter int          CNT_W   = 27,
  parameter int unsigned DEF_DIV = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             load,
  input  logic [CNT_W-1:0] data,
`ifdef TICK_GEN_SQUARE_EN
  output logic             sq,
`endif
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEFV = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic             wrap;

  // div is never zero, so div-1 cannot underflow
  assign wrap = (cnt == div - ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      div  <= DEFV;
      tick <= 1'b0;
    end else if (load) begin
      div  <= data;
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + ONE;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

`ifdef TICK_GEN_SQUARE_EN
  // Toggles exactly on the edges that register a tick; restart keeps the level
  always_ff @(posedge clk) begin
    if (reset || load)
      sq <= 1'b0;
    else if (!restart && en && wrap)
      sq <= ~sq;
  end
`endif

endmodule

module multi_tick_gen #(
  parameter int          NUM_CH  = 3,
  parameter int          CNT_W   = 27,
  parameter int unsigned DEF_DIV = 100000000
) (
  input  logic              Clk100M,
  input  logic              reset,
  input  logic              en,
  input  logic [NUM_CH-1:0] restart,
  input  logic [NUM_CH-1:0] div_wr,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
`ifdef TICK_GEN_SQUARE_EN
  output logic [NUM_CH-1:0] sq,
`endif
  output logic              div_err
);

  if (DEF_DIV == 0 || longint'(DEF_DIV) >= (longint'(1) << CNT_W)) begin : g_bad_param
    $error("multi_tick_gen: DEF_DIV must be in 1 .. 2**CNT_W-1");
  end

  logic              data_zero;
  logic [NUM_CH-1:0] load;

  // A zero write is rejected outright; the channel behaves as if no write happened
  assign data_zero = (div_data == '0);
  assign load      = div_wr & {NUM_CH{~data_zero}};

  always_ff @(posedge Clk100M) begin
    if (reset) div_err <= 1'b0;
    else       div_err <= (|div_wr) & data_zero;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
`ifdef TICK_GEN_SQUARE_EN
    tick_lane #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_lane (
      .clk     (Clk100M),
      .reset   (reset),
      .en      (en),
      .restart (restart[i]),
      .load    (load[i]),
      .data    (div_data),
      .sq      (sq[i]),
      .tick    (tick[i])
    );
`else
    tick_lane #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_lane (
      .clk     (Clk100M),
      .reset   (reset),
      .en      (en),
      .restart (restart[i]),
      .load    (load[i]),
      .data    (div_data),
      .tick    (tick[i])
    );
`endif
  end

endmodule
